// File: rtl/rs232_tx_queue_pkg.sv
// Shared constants and FSM encoding for the buffered RS-232 transmitter.
package rs232_tx_queue_pkg;

   localparam int BIT_CYCLES_DEF = 143;
   localparam int DEPTH_LOG_DEF  = 4;
   localparam int FRAME_BITS     = 10;
   localparam int DATA_BITS      = FRAME_BITS - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs232_tx_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, reused for the receive side later.
// A push while full is dropped even if a pop happens on the same edge.
module sync_fifo #(
   parameter int DEPTH_LOG = 4,
   parameter int WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_COUNT = DEPTH[DEPTH_LOG:0];

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic                 push_ok;
   logic                 pop_ok;

   assign full     = (count_q == FULL_COUNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at the depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + (DEPTH_LOG+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - (DEPTH_LOG+1)'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; written only on an accepted push so idle data never lands.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/rs232_tx_queue.sv
// rs232_tx_queue: CPU-side byte FIFO feeding an 8N1 serial transmitter on tx.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (tx low) for one bit time
//   DATA  | 8 data bits, LSB first, one bit time each
//   STOP  | stop bit (tx high); chains straight into START if more bytes wait
module rs232_tx_queue
   import rs232_tx_queue_pkg::*;
#(
   parameter int BIT_CYCLES = BIT_CYCLES_DEF,
   parameter int DEPTH_LOG  = DEPTH_LOG_DEF
) (
   input  logic               CLK,
   input  logic               XRST,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   output logic               full,
   output logic [DEPTH_LOG:0] count,
   output logic               overflow,
   output logic               busy,
   output logic               tx
);

   localparam int            CW        = cnt_width(BIT_CYCLES);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_e          state_q, state_d;
   logic [CW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;

   logic               fifo_pop;
   logic [7:0]         fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [DEPTH_LOG:0] fifo_count;
   logic               baud_end;

   sync_fifo #(
      .DEPTH_LOG (DEPTH_LOG),
      .WIDTH     (8)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (XRST),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign full     = fifo_full;
   assign count    = fifo_count;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign tx       = tx_q;
   assign baud_end = (baud_q == BAUD_LAST);

   // Overflow is sticky until reset; full is the pre-edge registered value.
   assign ovf_d = ovf_q | (wr_en & fifo_full);

   // Frame sequencer: tx and busy are computed here and registered, so the
   // line changes on the same edge the state does.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = ST_START;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ST_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  // Chain the next byte with no idle gap between frames.
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = ST_START;
                  tx_d     = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            baud_d  = '0;
         end
      endcase
   end

   // State, timing and line registers; reset drops the line high at once.
   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
